srl_fifo16: RTL
===============

SRL_FIFO16 -- requirements
Module: srl_fifo16

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 16, storage entries (power of two, 2..32).
REQ-003 SHALL have parameter IS_C_INVERTED, default 1'b0; when 1, all state updates on the falling edge of C.
REQ-004 SHALL have port C  input  1  clock; single clock domain.
REQ-005 SHALL have port CLR  input  1  asynchronous active-low reset.
REQ-006 SHALL have port CE  input  1  global clock enable; 0 freezes all state.
REQ-007 SHALL have port WR_VLD  input  1  write request.
REQ-008 SHALL have port WR_RDY  output  1  FIFO can accept a write.
REQ-009 SHALL have port WR_DAT  input  WIDTH  write data.
REQ-010 SHALL have port RD_VLD  output  1  head entry available.
REQ-011 SHALL have port RD_RDY  input  1  consumer accepts head entry.
REQ-012 SHALL have port RD_DAT  output  WIDTH  head entry data.
REQ-013 SHALL have port CNT  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL store entries in a shift-register array: an accepted write shifts all entries up one position and loads WR_DAT into position 0, with no clear on the array.
REQ-015 SHALL hold an occupancy counter CNT in 0..DEPTH; the head entry is at array position CNT-1.
REQ-016 SHALL drive WR_RDY = CE & (CNT != DEPTH) and RD_VLD = CE & (CNT != 0), combinationally.
REQ-017 SHALL accept a write on the active clock edge when WR_VLD & WR_RDY, and a read when RD_VLD & RD_RDY.
REQ-018 SHALL drive RD_DAT = array[CNT-1] when RD_VLD=1 and all-zeros otherwise, combinationally.
REQ-019 SHALL update CNT per edge as follows: write only +1; read only -1; both or neither unchanged.
REQ-020 SHALL, on simultaneous read and write, shift the array and keep CNT, so the next head is the former second-oldest entry.
REQ-021 SHALL give write-to-read latency of one edge: a write accepted into an empty FIFO makes RD_VLD=1 with that data immediately after the edge.
REQ-022 SHALL have no read-to-write fall-through when full: WR_RDY stays 0 while CNT=DEPTH, even if a read is accepted in the same cycle.
REQ-023 SHALL ignore WR_VLD when WR_RDY=0 and RD_RDY when RD_VLD=0, with no state change and no error.
REQ-024 SHALL hold the array and CNT on every edge while CE=0; WR_RDY and RD_VLD read 0 for that cycle.
REQ-025 SHALL never wrap CNT: CNT never exceeds DEPTH and never goes below 0.

Reset
REQ-026 SHALL, while CLR=0, immediately force CNT=0, RD_VLD=0 and RD_DAT=0, and force WR_RDY=0 regardless of CE.
REQ-027 SHALL leave array contents undefined after reset; they are not observable while CNT=0.
REQ-028 SHALL, on CLR asserted mid-operation, discard all entries, so a handshake in the same cycle has no effect.
REQ-029 SHALL, after CLR deasserts, accept the first write on the next active edge with CE=1.

Verification
REQ-030 SHALL be checked with: reset, then write 0x11,0x22,0x33 on consecutive edges with RD_RDY=0 -> CNT=3, RD_VLD=1, RD_DAT=0x11.
REQ-031 SHALL be checked with: write 16 entries 0x00..0x0F with RD_RDY=0 -> after the 16th edge, WR_RDY=0 and CNT=16; a 17th write of 0xFF is ignored; 16 reads return 0x00..0x0F in order, then RD_VLD=0 and RD_DAT=0.
REQ-032 SHALL be checked with: CNT=5, WR_VLD=RD_RDY=1 for 10 edges with data 0xA0.. -> CNT remains 5, and the read sequence is the 5 old entries followed by 0xA0..0xA4.
REQ-033 SHALL be checked with: full FIFO, WR_VLD=RD_RDY=1 for one edge -> one read accepted, write rejected, CNT=15.
REQ-034 SHALL be checked with: CNT=7, CE=0 for 4 edges with WR_VLD=RD_RDY=1 -> CNT stays 7 and WR_RDY=RD_VLD=0; after CE returns to 1, RD_DAT equals the pre-freeze head.
REQ-035 SHALL be checked with: CNT=9, CLR pulsed low between edges -> CNT=0, RD_VLD=0 and RD_DAT=0 without a clock edge; a write of 0x5A after release gives RD_DAT=0x5A and CNT=1.

Source files
------------

// File: rtl/srl_fifo16.sv
// srl_fifo16: shift-register FIFO with valid/ready handshakes and an occupancy count.
// New data enters at position 0, so the head entry sits at position CNT-1.
module srl_fifo16 #(
    parameter int   WIDTH         = 8,
    parameter int   DEPTH         = 16,
    parameter logic IS_C_INVERTED = 1'b0
) (
    input  logic                     C,
    input  logic                     CLR,
    input  logic                     CE,
    input  logic                     WR_VLD,
    output logic                     WR_RDY,
    input  logic [WIDTH-1:0]         WR_DAT,
    output logic                     RD_VLD,
    input  logic                     RD_RDY,
    output logic [WIDTH-1:0]         RD_DAT,
    output logic [$clog2(DEPTH):0]   CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic             clk;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr;
    logic             rd;
    logic [AW-1:0]    head;
    assign clk = C ^ IS_C_INVERTED;
    // CLR gates WR_RDY so no write can slip in while reset is held
    always_comb begin
        WR_RDY = CE & CLR & (CNT != CW'(DEPTH));
        RD_VLD = CE & (CNT != '0);
        wr     = WR_VLD & WR_RDY;
        rd     = RD_VLD & RD_RDY;
        head   = AW'(CNT - CW'(1));
        RD_DAT = RD_VLD ? mem[head] : '0;
    end
    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR)
            CNT <= '0;
        else
            CNT <= (wr && !rd) ? CNT + CW'(1) : (rd && !wr) ? CNT - CW'(1) : CNT;
    end
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[0] <= WR_DAT;
            for (int i = 1; i < DEPTH; i++)
                mem[i] <= mem[i-1];
        end
    end
endmodule
